vga_pixel_unpack: RTL and testbench
===================================

VGA_PIXEL_UNPACK -- requirements
Module: vga_pixel_unpack

Interface
REQ-001 Parameter WORD_WIDTH, default 64, width of one frame-buffer word popped from the tx FIFO.
REQ-002 clk_i  input  1  pixel-domain clock; one clock, reset asynchronous and active-low.
REQ-003 rst_n_i  input  1  asynchronous active-low reset.
REQ-004 en_i  input  1  unpacker enable (norm mode); low acts as flush.
REQ-005 flush_i  input  1  synchronous clear of held word and index.
REQ-006 mode_i  input  2  colour mode: 00 RGB565, 01 xRGB8888, 10 GRAY8, 11 reserved (treated as xRGB8888).
REQ-007 word_valid_i  input  1  FIFO not empty.
REQ-008 word_ready_o  output  1  FIFO pop strobe.
REQ-009 word_data_i  input  WORD_WIDTH  FIFO head word.
REQ-010 pix_valid_o  output  1  pixel available to timing core.
REQ-011 pix_ready_i  input  1  timing core consumes pixel (active-video cycle).
REQ-012 pix_r_o / pix_g_o / pix_b_o  output  8 each  pixel colour.
REQ-013 underrun_o  output  1  one-cycle pulse: pix_ready_i high while pix_valid_o low and en_i high.

Function
REQ-014 Pixels per word SHALL be: RGB565 4, xRGB8888 2, GRAY8 8; pixel 0 at word LSBs, ascending.
REQ-015 RGB565 pixel [15:11]=R,[10:5]=G,[4:0]=B SHALL expand by MSB replication (R8={R5,R5[4:2]}, G8={G6,G6[5:4]}).
REQ-016 xRGB8888 pixel [23:16]=R,[15:8]=G,[7:0]=B; bits [31:24] ignored.
REQ-017 GRAY8 byte SHALL drive R=G=B=byte.
REQ-018 State: held word register, held mode, pixel index (3 bits), full flag; two states EMPTY (full=0) and HOLD (full=1).
REQ-019 pix_valid_o SHALL equal full; colour outputs combinationally decode held word at index with held mode.
REQ-020 Pixel transfer occurs on pix_valid_o && pix_ready_i; index increments by one per transfer.
REQ-021 Last pixel = index equals pixels-per-word minus 1 for held mode.
REQ-022 word_ready_o SHALL be en_i && ~flush_i && word_valid_i && (~full || last-pixel transfer this cycle).
REQ-023 On word_ready_o: load word, sample mode_i into held mode, index<=0, full<=1 (zero-bubble back-to-back).
REQ-024 Last-pixel transfer without new word: full<=0, index<=0.
REQ-025 Latency word_valid_i to pix_valid_o SHALL be one cycle from EMPTY.
REQ-026 mode_i change while HOLD SHALL not affect the held word; takes effect at next load.
REQ-027 flush_i or ~en_i SHALL clear full and index next cycle and suppress word_ready_o and underrun_o that cycle; flush wins over simultaneous load/transfer.
REQ-028 pix_ready_i with pix_valid_o low SHALL not change state, only pulse underrun_o.
REQ-029 word_valid_i low during HOLD SHALL not affect pixel output.

Reset
REQ-030 Reset SHALL clear full, index, held word, held mode (00) and underrun_o; outputs pix_valid_o=0, word_ready_o=0, colour=0.
REQ-031 Reset mid-word SHALL discard the held word; no pop issued until reset deasserts.

Structure
REQ-032 Mode encodings, pixels-per-word constants and 8-bit colour width SHALL live in the shared vga_define package/header beside existing VGA register macros.
REQ-033 One sub-module natural: vga_pixel_decode (combinational word+index+mode -> RGB888), reused by test pattern path.
REQ-034 Block instantiated between u_tx_fifo pop side and the timing core pixel port.

Verification
REQ-035 RGB565, word 0xFFFF_F800_07E0_001F, pix_ready_i held high -> pixels (00,00,FF),(00,FF,00),(FF,00,00),(FF,FF,FF), one per cycle.
REQ-036 GRAY8, two back-to-back words 0x0706050403020100 and 0x0F0E...08 -> 16 consecutive pixels gray 00..0F, no bubble, word_ready_o pulses on cycle of pixel 7.
REQ-037 xRGB8888 word 0xAA123456_BB654321 then mode_i switched to GRAY8 after load -> pixels (65,43,21),(12,34,56) only; next word decoded as GRAY8.
REQ-038 FIFO empty, pix_ready_i high 3 cycles with en_i=1 -> underrun_o high 3 cycles, pix_valid_o=0, no pop.
REQ-039 flush_i asserted after 2 of 4 RGB565 pixels, simultaneous with word_valid_i -> no pop that cycle, pix_valid_o=0 next cycle, following word starts at pixel 0.
REQ-040 rst_n_i asserted asynchronously mid-word -> pix_valid_o and word_ready_o drop immediately, all state zero after release.

Source files
------------

// File: rtl/vga_pixel_unpack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_unpack_pkg
// Purpose  : Shared colour-mode encodings, pixels-per-word constants, the
//            unpacker state encoding and a last-index helper for the
//            frame-buffer pixel unpack path.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pixel_unpack_pkg;

   // Width of one output colour channel
   localparam int COLOR_W = 8;

   // Width of the pixel index inside a held word
   localparam int IDX_W = 3;

   // Colour modes as presented on mode_i; the reserved code decodes as xRGB8888
   typedef enum logic [1:0] {
      MODE_RGB565   = 2'b00,
      MODE_XRGB8888 = 2'b01,
      MODE_GRAY8    = 2'b10,
      MODE_RSVD     = 2'b11
   } pix_mode_e;

   // Pixels carried by one 64-bit frame-buffer word in each mode
   localparam int PPW_RGB565   = 4;
   localparam int PPW_XRGB8888 = 2;
   localparam int PPW_GRAY8    = 8;

   // Unpacker occupancy: EMPTY holds no word, HOLD has pixels left to emit
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } unpack_state_e;

   // Index of the final pixel within a word for the given mode
   function automatic logic [IDX_W-1:0] last_index(input logic [1:0] mode);
      logic [IDX_W-1:0] idx;
      case (mode)
         MODE_RGB565: idx = IDX_W'(PPW_RGB565 - 1);
         MODE_GRAY8:  idx = IDX_W'(PPW_GRAY8 - 1);
         default:     idx = IDX_W'(PPW_XRGB8888 - 1);
      endcase
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pixel_unpack_decode.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_unpack_decode
// Purpose  : Combinational decode of one pixel from a packed frame-buffer
//            word, selected by pixel index and colour mode, to RGB888.
//            Shared with the test-pattern path.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pixel_unpack_decode
   import vga_pixel_unpack_pkg::*;
#(
   parameter int WORD_WIDTH = 64
) (
   input  logic [WORD_WIDTH-1:0] word_i,
   input  logic [IDX_W-1:0]      idx_i,
   input  logic [1:0]            mode_i,
   output logic [COLOR_W-1:0]    r_o,
   output logic [COLOR_W-1:0]    g_o,
   output logic [COLOR_W-1:0]    b_o
);

   logic [15:0]        px16;
   logic [7:0]         shamt32;
   logic [COLOR_W-1:0] x_r;
   logic [COLOR_W-1:0] x_g;
   logic [COLOR_W-1:0] x_b;
   logic [COLOR_W-1:0] gray;

   // Extract the addressed pixel field for each packing; pixel 0 sits at the LSBs
   always_comb begin
      px16    = 16'(word_i >> {idx_i, 4'b0000});
      shamt32 = {idx_i, 5'b00000};
      x_b     = COLOR_W'(word_i >> shamt32);
      x_g     = COLOR_W'(word_i >> (shamt32 + 8'd8));
      x_r     = COLOR_W'(word_i >> (shamt32 + 8'd16));
      gray    = COLOR_W'(word_i >> {idx_i, 3'b000});
   end

   // Select the mode; RGB565 channels widen by replicating their MSBs into the LSBs
   always_comb begin
      r_o = '0;
      g_o = '0;
      b_o = '0;
      case (mode_i)
         MODE_RGB565: begin
            r_o = {px16[15:11], px16[15:13]};
            g_o = {px16[10:5],  px16[10:9]};
            b_o = {px16[4:0],   px16[4:2]};
         end
         MODE_GRAY8: begin
            r_o = gray;
            g_o = gray;
            b_o = gray;
         end
         default: begin
            r_o = x_r;
            g_o = x_g;
            b_o = x_b;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/vga_pixel_unpack.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_unpack
// Purpose  : Pops packed frame-buffer words from the tx FIFO and presents
//            them one pixel at a time to the timing core, with zero-bubble
//            back-to-back word loading, flush and underrun reporting.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pixel_unpack
   import vga_pixel_unpack_pkg::*;
#(
   parameter int WORD_WIDTH = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  en_i,
   input  logic                  flush_i,
   input  logic [1:0]            mode_i,
   input  logic                  word_valid_i,
   output logic                  word_ready_o,
   input  logic [WORD_WIDTH-1:0] word_data_i,
   output logic                  pix_valid_o,
   input  logic                  pix_ready_i,
   output logic [COLOR_W-1:0]    pix_r_o,
   output logic [COLOR_W-1:0]    pix_g_o,
   output logic [COLOR_W-1:0]    pix_b_o,
   output logic                  underrun_o
);

   unpack_state_e         state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [WORD_WIDTH-1:0] word_q, word_d;
   logic [1:0]            mode_q, mode_d;
   logic                  underrun_q, underrun_d;

   logic active;
   logic full;
   logic last;
   logic xfer;
   logic last_xfer;
   logic pop;

   // Handshake terms; flush or disable blocks any pop, and reset blocks it immediately
   always_comb begin
      active    = en_i & ~flush_i;
      full      = (state_q == ST_HOLD);
      last      = (idx_q == last_index(mode_q));
      xfer      = full & pix_ready_i;
      last_xfer = xfer & last;
      pop       = rst_n_i & active & word_valid_i & (~full | last_xfer);
   end

   assign word_ready_o = pop;
   assign pix_valid_o  = full;
   assign underrun_o   = underrun_q;

   // Next state: flush dominates, then word load, then pixel advance
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      word_d     = word_q;
      mode_d     = mode_q;
      underrun_d = active & pix_ready_i & ~full;
      if (!active) begin
         state_d = ST_EMPTY;
         idx_d   = '0;
      end else if (pop) begin
         state_d = ST_HOLD;
         idx_d   = '0;
         word_d  = word_data_i;
         mode_d  = mode_i;
      end else if (last_xfer) begin
         state_d = ST_EMPTY;
         idx_d   = '0;
      end else if (xfer) begin
         idx_d   = idx_q + IDX_W'(1);
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_EMPTY;
         idx_q      <= '0;
         word_q     <= '0;
         mode_q     <= MODE_RGB565;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         word_q     <= word_d;
         mode_q     <= mode_d;
         underrun_q <= underrun_d;
      end
   end

   vga_pixel_unpack_decode #(
      .WORD_WIDTH (WORD_WIDTH)
   ) u_decode (
      .word_i (word_q),
      .idx_i  (idx_q),
      .mode_i (mode_q),
      .r_o    (pix_r_o),
      .g_o    (pix_g_o),
      .b_o    (pix_b_o)
   );

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_unpack.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_pixel_unpack
// Purpose  : Scoreboard bench for vga_pixel_unpack. A FIFO-like driver feeds
//            words; expected pixels come from an arithmetic colour model and
//            are compared by a monitor on every pixel handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_unpack;

   typedef struct {
      logic [63:0] w;
      logic [1:0]  m;
   } src_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        flush;
   wire  [1:0]  mode;
   wire         word_valid;
   wire  [63:0] word_data;
   wire         pix_ready;
   logic        word_ready;
   logic        pix_valid;
   logic [7:0]  pix_r, pix_g, pix_b;
   logic        underrun;

   // manual and driver-owned copies of the streaming inputs
   logic        drv_en;
   logic        m_valid, d_valid;
   logic [63:0] m_data, d_data;
   logic [1:0]  m_mode, d_mode;
   logic        m_ready, d_ready;
   logic        rdy_rand, val_rand;

   assign word_valid = drv_en ? d_valid : m_valid;
   assign word_data  = drv_en ? d_data  : m_data;
   assign mode       = drv_en ? d_mode  : m_mode;
   assign pix_ready  = drv_en ? d_ready : m_ready;

   src_t        src_q[$];
   logic [23:0] exp_q[$];
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   vga_pixel_unpack #(.WORD_WIDTH(64)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .en_i         (en),
      .flush_i      (flush),
      .mode_i       (mode),
      .word_valid_i (word_valid),
      .word_ready_o (word_ready),
      .word_data_i  (word_data),
      .pix_valid_o  (pix_valid),
      .pix_ready_i  (pix_ready),
      .pix_r_o      (pix_r),
      .pix_g_o      (pix_g),
      .pix_b_o      (pix_b),
      .underrun_o   (underrun)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // colour model: pixel list of a word, from the packing rules in plain arithmetic
   function automatic int model(input logic [63:0] w, input logic [1:0] m,
                                output logic [23:0] px [8]);
      int n;
      longint unsigned v, p;
      int r, g, b, r5, g6, b5;
      v = w;
      for (int k = 0; k < 8; k++) px[k] = '0;
      if (m == 2'd0) begin
         n = 4;
         for (int k = 0; k < 4; k++) begin
            p  = (v >> (16 * k)) & 64'hFFFF;
            r5 = int'(p / 2048);
            g6 = int'((p / 32) % 64);
            b5 = int'(p % 32);
            r  = r5 * 8 + r5 / 4;
            g  = g6 * 4 + g6 / 16;
            b  = b5 * 8 + b5 / 4;
            px[k] = {8'(r), 8'(g), 8'(b)};
         end
      end else if (m == 2'd2) begin
         n = 8;
         for (int k = 0; k < 8; k++) begin
            g = int'((v >> (8 * k)) & 64'hFF);
            px[k] = {8'(g), 8'(g), 8'(g)};
         end
      end else begin
         n = 2;
         for (int k = 0; k < 2; k++) begin
            p = v >> (32 * k);
            r = int'((p >> 16) & 64'hFF);
            g = int'((p >> 8) & 64'hFF);
            b = int'(p & 64'hFF);
            px[k] = {8'(r), 8'(g), 8'(b)};
         end
      end
      return n;
   endfunction

   task automatic push_exp(input logic [63:0] w, input logic [1:0] m, input int count);
      logic [23:0] px [8];
      int n;
      n = model(w, m, px);
      if (count < n) n = count;
      for (int k = 0; k < n; k++) exp_q.push_back(px[k]);
   endtask

   task automatic push_word(input logic [63:0] w, input logic [1:0] m);
      src_t s;
      s.w = w;
      s.m = m;
      push_exp(w, m, 8);
      src_q.push_back(s);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && (exp_q.size() > 0 || src_q.size() > 0); i++)
         @(negedge clk);
      chk("drain_left", 64'(exp_q.size()), 64'd0);
      @(negedge clk);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // FIFO model: present the head word, retire it on a pop strobe
   initial begin : driver
      logic pop_seen;
      d_valid = 1'b0;
      d_data  = '0;
      d_mode  = '0;
      d_ready = 1'b0;
      forever begin
         @(negedge clk);
         pop_seen = drv_en && word_valid && word_ready;
         @(posedge clk);
         #1;
         if (drv_en) begin
            if (pop_seen && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() > 0) begin
               d_mode  = src_q[0].m;
               d_data  = src_q[0].w;
               d_valid = !val_rand || ($urandom_range(9) < 7);
            end else begin
               d_mode  = 2'($urandom_range(3));
               d_data  = {$urandom, $urandom};
               d_valid = 1'b0;
            end
            d_ready = rdy_rand ? ($urandom_range(9) < 6) : 1'b1;
         end
      end
   end

   // scoreboard monitor: every pixel handshake consumes one expected pixel
   initial begin : monitor
      logic [23:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
               chk("pixel_unexpected", {40'd0, pix_r, pix_g, pix_b}, 64'hDEAD);
            end else begin
               e = exp_q.pop_front();
               chk("pixel", {40'd0, pix_r, pix_g, pix_b}, {40'd0, e});
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int k, bubbles;
      bit seen;
      rst_n = 1'b0; en = 1'b1; flush = 1'b0;
      drv_en = 1'b0; rdy_rand = 1'b0; val_rand = 1'b0;
      m_valid = 1'b1; m_data = 64'h1234_5678_9ABC_DEF0; m_mode = 2'd0; m_ready = 1'b1;

      // reset state with a word pending and consumer ready
      repeat (3) @(negedge clk);
      chk("rst_pix_valid", 64'(pix_valid), 64'd0);
      chk("rst_word_ready", 64'(word_ready), 64'd0);
      chk("rst_colour", {40'd0, pix_r, pix_g, pix_b}, 64'd0);
      chk("rst_underrun", 64'(underrun), 64'd0);
      m_valid = 1'b0; m_ready = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", 64'(pix_valid), 64'd0);

      // RGB565 primaries and white, consumer always ready
      push_word(64'hFFFF_F800_07E0_001F, 2'd0);
      drv_en = 1'b1;
      drain(100);

      // two GRAY8 words back to back: no bubble, pop on pixel 7
      push_word(64'h0706_0504_0302_0100, 2'd2);
      push_word(64'h0F0E_0D0C_0B0A_0908, 2'd2);
      k = 0; bubbles = 0; seen = 0;
      for (int i = 0; i < 60 && k < 16; i++) begin
         @(negedge clk);
         if (pix_valid) seen = 1;
         else if (seen) bubbles++;
         if (pix_valid && pix_ready) begin
            if (k == 7) chk("pop_at_pix7", 64'(word_ready), 64'd1);
            k++;
         end
      end
      chk("gray_count", 64'(k), 64'd16);
      chk("gray_bubbles", 64'(bubbles), 64'd0);
      drain(50);

      // xRGB8888 word with mode switching to GRAY8 while it is held
      push_word(64'hAA12_3456_BB65_4321, 2'd1);
      push_word(64'h8877_6655_4433_2211, 2'd2);
      drain(100);

      // random words, modes, FIFO gaps and consumer stalls
      rdy_rand = 1'b1; val_rand = 1'b1;
      for (int i = 0; i < 40; i++)
         push_word({$urandom, $urandom}, 2'($urandom_range(3)));
      drain(4000);
      drv_en = 1'b0;
      m_valid = 1'b0; m_ready = 1'b0;
      step();

      // underrun: empty FIFO with consumer ready for three cycles
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ur_pix_valid", 64'(pix_valid), 64'd0);
         chk("ur_no_pop", 64'(word_ready), 64'd0);
         chk("ur_pulse", 64'(underrun), (i > 0) ? 64'd1 : 64'd0);
         step();
      end
      m_ready = 1'b0;
      @(negedge clk);
      chk("ur_pulse", 64'(underrun), 64'd1);
      @(negedge clk);
      chk("ur_end", 64'(underrun), 64'd0);
      step();
      en = 1'b0; m_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("ur_en_low", 64'(underrun), 64'd0);
      step();
      en = 1'b1; m_ready = 1'b0;

      // flush after two of four RGB565 pixels, with a new word offered
      step();
      m_valid = 1'b1; m_data = 64'h1234_ABCD_F00F_0FF0; m_mode = 2'd0; m_ready = 1'b1;
      push_exp(m_data, 2'd0, 2);
      @(negedge clk);
      chk("fl_load_pop", 64'(word_ready), 64'd1);
      step();
      m_valid = 1'b0;
      step();
      step();
      m_ready = 1'b0; flush = 1'b1; m_valid = 1'b1; m_data = {$urandom, $urandom};
      @(negedge clk);
      chk("fl_no_pop", 64'(word_ready), 64'd0);
      step();
      flush = 1'b0; m_ready = 1'b1;
      push_exp(m_data, 2'd0, 8);
      @(negedge clk);
      chk("fl_clears_valid", 64'(pix_valid), 64'd0);
      chk("fl_next_pop", 64'(word_ready), 64'd1);
      step();
      m_valid = 1'b0;
      drain(50);

      // disable acts as a flush
      step();
      m_valid = 1'b1; m_data = {$urandom, $urandom}; m_mode = 2'd2; m_ready = 1'b0;
      step();
      en = 1'b0;
      @(negedge clk);
      chk("en_low_no_pop", 64'(word_ready), 64'd0);
      chk("en_low_still_held", 64'(pix_valid), 64'd1);
      step();
      en = 1'b1; m_valid = 1'b0;
      @(negedge clk);
      chk("en_low_clears", 64'(pix_valid), 64'd0);

      // asynchronous reset while a word is held
      step();
      m_valid = 1'b1; m_data = 64'hFEDC_BA98_7654_3210; m_mode = 2'd2;
      step();
      @(negedge clk);
      chk("hold_before_rst", 64'(pix_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pix_valid", 64'(pix_valid), 64'd0);
      chk("arst_word_ready", 64'(word_ready), 64'd0);
      chk("arst_colour", {40'd0, pix_r, pix_g, pix_b}, 64'd0);
      @(negedge clk);
      chk("in_rst_no_pop", 64'(word_ready), 64'd0);
      m_valid = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("rel_pix_valid", 64'(pix_valid), 64'd0);
      chk("rel_colour", {40'd0, pix_r, pix_g, pix_b}, 64'd0);
      chk("rel_underrun", 64'(underrun), 64'd0);
      step();
      m_valid = 1'b1; m_data = 64'h8000_0400_0010_7BEF; m_mode = 2'd0; m_ready = 1'b1;
      push_exp(m_data, 2'd0, 8);
      step();
      m_valid = 1'b0;
      drain(50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
